bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning the number of requesters (N >= 2).
REQ-002 The module SHALL have parameter WIDTH, default 8, meaning the payload width per requester.
REQ-003 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles without bus_ready before a forced release (TIMEOUT >= 1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N  request per requester; held high until that requester's ack.
REQ-007 req_data  input  N*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 bus_ready  input  1  downstream accepts the current beat.
REQ-009 gnt  output  N  registered one-hot grant, all-zero when idle; usable directly as a priority-mux select.
REQ-010 gnt_idx  output  $clog2(N)  registered binary index of the granted requester; 0 when idle.
REQ-011 bus_valid  output  1  high exactly while in BUSY.
REQ-012 bus_data  output  WIDTH  req_data slice selected by gnt_idx; combinational.
REQ-013 ack  output  N  gnt AND replicated bus_ready; combinational.
REQ-014 timeout_err  output  1  registered one-cycle pulse on a forced release.

Function
REQ-015 The arbiter SHALL implement two states: IDLE and BUSY.
REQ-016 In IDLE with req nonzero, the arbiter SHALL pick as winner the first set req bit scanning upward from ptr with wrap at N, and enter BUSY next cycle with gnt/gnt_idx loaded (request-to-grant latency 1 cycle).
REQ-017 In IDLE with req all-zero, the arbiter SHALL remain in IDLE with gnt = 0.
REQ-018 In BUSY, gnt and gnt_idx SHALL stay stable until release, regardless of other req changes.
REQ-019 In BUSY, a cycle with bus_ready = 1 SHALL complete the transfer: next cycle state = IDLE, gnt = 0, ptr = (gnt_idx + 1) mod N.
REQ-020 Between consecutive grants there SHALL be exactly one IDLE cycle.
REQ-021 In BUSY, if req[gnt_idx] drops before bus_ready, the arbiter SHALL abort: next cycle IDLE, ptr advances as in REQ-019, no error.
REQ-022 A BUSY cycle counter SHALL clear on BUSY entry; when it reaches TIMEOUT with bus_ready still low, the arbiter SHALL release as in REQ-019 and pulse timeout_err for one cycle.
REQ-023 If bus_ready and the timeout condition coincide, completion SHALL take precedence, with no timeout_err.
REQ-024 ptr SHALL wrap from N-1 to 0.
REQ-025 Each requester SHALL be granted within N grants of asserting req, with no starvation.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state = IDLE, gnt = 0, gnt_idx = 0, ptr = 0, counter = 0, timeout_err = 0, and therefore bus_valid = 0 and ack = 0.
REQ-027 A reset asserted mid-transfer SHALL drop the grant with no ack; after release, arbitration restarts from requester 0.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, BUSY) and the default N, WIDTH and TIMEOUT constants.
REQ-029 bus_data SHALL be produced by one instance of the team's binary-select mux sub-module, nmux (N, WIDTH, sel = gnt_idx).
REQ-030 The round-robin winner search SHALL be pure combinational logic with no further sub-modules.

Verification
REQ-031 Scenario: N = 3, req = 3'b001, bus_ready high at the first BUSY cycle -> gnt = 001 one cycle after req, ack[0] pulses, bus_data = req_data[7:0], then one IDLE cycle.
REQ-032 Scenario: req = 3'b111 held, bus_ready always 1 -> grants in the order 0, 1, 2, 0, separated by single IDLE cycles.
REQ-033 Scenario: grant to 1, then req[2] rises while BUSY -> gnt stays 010 until bus_ready; the next grant goes to 2.
REQ-034 Scenario: TIMEOUT = 4, bus_ready held 0 -> release after 4 BUSY cycles, timeout_err high exactly one cycle, ptr advanced.
REQ-035 Scenario: rst_n pulsed low during BUSY with gnt = 100 -> gnt = 0 immediately; after release with req = 3'b110, the next grant goes to requester 1.
REQ-036 Scenario: req[gnt_idx] dropped mid-BUSY -> IDLE next cycle, no ack, timeout_err stays 0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N       = 3;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/nmux.sv
// Binary-select N-way mux over a flat bus of WIDTH-bit slices.
module nmux #(
    parameter int N     = 3,
    parameter int WIDTH = 8
) (
    input  logic [N*WIDTH-1:0]     data,
    input  logic [$clog2(N)-1:0]   sel,
    output logic [WIDTH-1:0]       y
);

    localparam int SW = $clog2(N);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                y = data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter: one grant at a time, released on completion, requester abort or timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic [N*WIDTH-1:0]    req_data,
    input  logic                  bus_ready,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic [N-1:0]          ack,
    output logic                  timeout_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_next;
    logic [N-1:0]   gnt_next;
    logic [IW-1:0]  idx_next, ptr, ptr_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           terr_next;

    logic [IW-1:0]  lo_idx, hi_idx, win_idx;
    logic           lo_found, hi_found, win_found;
    logic           timeout_hit, owner_req, release_now;

    // Lowest set request overall, and lowest at or above ptr; the latter wins, else wrap.
    always_comb begin
        lo_idx   = '0;
        lo_found = 1'b0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx   = IW'(i);
                lo_found = 1'b1;
                if (IW'(i) >= ptr) begin
                    hi_idx   = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign owner_req   = req[gnt_idx];
    assign release_now = bus_ready || !owner_req || timeout_hit;

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        idx_next   = gnt_idx;
        ptr_next   = ptr;
        cnt_next   = cnt;
        terr_next  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next        = BUSY;
                    gnt_next          = '0;
                    gnt_next[win_idx] = 1'b1;
                    idx_next          = win_idx;
                    cnt_next          = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    idx_next   = '0;
                    cnt_next   = '0;
                    ptr_next   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                    // Completion and abort both outrank the timeout.
                    terr_next  = !bus_ready && owner_req;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_next;
            gnt         <= gnt_next;
            gnt_idx     <= idx_next;
            ptr         <= ptr_next;
            cnt         <= cnt_next;
            timeout_err <= terr_next;
        end
    end

    assign bus_valid = (state == BUSY);
    assign ack       = gnt & {N{bus_ready}};

    nmux #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_nmux (
        .data (req_data),
        .sel  (gnt_idx),
        .y    (bus_data)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand sequences, randomized run vs model.
module tb_bus_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 4;
    localparam logic [N*W-1:0] DATA = 24'hC3B2A1;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           bus_ready;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_idx;
    logic           bus_valid;
    logic [W-1:0]   bus_data;
    logic [N-1:0]   ack;
    logic           timeout_err;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .bus_ready   (bus_ready),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .ack         (ack),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic [2:0] ack;
        logic       terr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] d, input int idx);
        logic [N*W-1:0] s;
        s = d >> (idx * W);
        return s[W-1:0];
    endfunction

    task automatic check_outs(input string tag, input logic [2:0] eg, input logic [1:0] ei,
                              input logic ev, input logic [2:0] ea, input logic et);
        check({tag, ".gnt"},   32'(gnt),         32'(eg));
        check({tag, ".idx"},   32'(gnt_idx),     32'(ei));
        check({tag, ".valid"}, 32'(bus_valid),   32'(ev));
        check({tag, ".ack"},   32'(ack),         32'(ea));
        check({tag, ".terr"},  32'(timeout_err), 32'(et));
        check({tag, ".data"},  32'(bus_data),    32'(slice_of(req_data, int'(ei))));
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, then advance past the edge.
    task automatic step(input string tag, input logic [2:0] r, input logic rdy, input logic [2:0] eg,
                        input logic [1:0] ei, input logic ev, input logic [2:0] ea, input logic et);
        req       = r;
        bus_ready = rdy;
        @(negedge clk);
        check_outs(tag, eg, ei, ev, ea, et);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: who owns the bus, where the round-robin search starts, BUSY cycles so far.
    int m_owner;
    int m_ptr;
    int m_busy;
    logic m_terr;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_busy  = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] r, input logic rdy);
        m_terr = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 0;
                end
            end
        end else begin
            m_busy++;
            if (rdy || !r[m_owner] || m_busy >= TO) begin
                m_terr  = !rdy && r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    logic [2:0] m_gnt;
    logic [1:0] m_idx;
    logic [2:0] flip;
    int         grants [N];

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        bus_ready = 1'b0;
        req_data  = DATA;

        #2;
        check_outs("reset", 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //            rst   req     rdy   gnt     idx  valid ack     terr
        tbl[0]  = '{1'b0, 3'b001, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[3]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[4]  = '{1'b1, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b0};
        tbl[8]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[9]  = '{1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 1'b1, 3'b100, 1'b0};
        tbl[10] = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};
        tbl[11] = '{1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b0};
        tbl[12] = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].rdy, tbl[i].gnt, tbl[i].idx,
                 tbl[i].valid, tbl[i].ack, tbl[i].terr);
        end

        // Late request from 2 does not disturb grant 1; 2 wins next (ptr starts at 1).
        step("hold1", 3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("hold2", 3'b110, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        step("hold3", 3'b110, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        step("hold4", 3'b110, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b0);
        step("hold5", 3'b100, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("hold6", 3'b100, 1'b1, 3'b100, 2'd2, 1'b1, 3'b100, 1'b0);
        step("hold7", 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);

        // Timeout after exactly TO busy cycles, one-cycle error pulse, ptr moves past 0.
        step("to1",  3'b001, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("to2",  3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        step("to3",  3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        step("to4",  3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        step("to5",  3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        step("to6",  3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b1);
        step("to7",  3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("to8",  3'b011, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("to9",  3'b011, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b0);
        step("to10", 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);

        // Asynchronous reset during a grant to 2; arbitration then restarts at requester 0.
        step("rst1", 3'b100, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("rst2", 3'b100, 1'b0, 3'b100, 2'd2, 1'b1, 3'b000, 1'b0);
        bus_ready = 1'b1;
        #1;
        check("rst_pre.ack", 32'(ack), 32'(3'b100));
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst3", 3'b110, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("rst4", 3'b110, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b0);
        step("rst5", 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);

        // Requester withdraws mid-transfer: back to IDLE, no ack, no error.
        step("abt1", 3'b100, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("abt2", 3'b100, 1'b0, 3'b100, 2'd2, 1'b1, 3'b000, 1'b0);
        step("abt3", 3'b000, 1'b0, 3'b100, 2'd2, 1'b1, 3'b000, 1'b0);
        step("abt4", 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        step("abt5", 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int b = 0; b < N; b++) grants[b] = 0;
        req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
            req       = req ^ flip;
            bus_ready = ($urandom_range(0, 2) == 0);
            req_data  = N*W'($urandom);
            m_gnt = '0;
            m_idx = '0;
            if (m_owner >= 0) begin
                m_gnt[m_owner] = 1'b1;
                m_idx = 2'(m_owner);
                grants[m_owner]++;
            end
            @(negedge clk);
            check_outs($sformatf("rnd%0d", c), m_gnt, m_idx, m_owner >= 0,
                       bus_ready ? m_gnt : 3'b000, m_terr);
            @(posedge clk);
            model_step(req, bus_ready);
            #1;
        end
        for (int b = 0; b < N; b++) check($sformatf("rnd_served%0d", b), 32'(grants[b] > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
